// File: rtl/spi_mem_responder_if.sv
// SPI bus and side-band load port between the nanoV CPU (or a testbench) and
// the SPI memory responder.
interface spi_mem_responder_if #(
   parameter int ADDR_BITS = 10
);
   logic                 spi_select;
   logic                 spi_mosi;
   logic                 spi_miso;
   logic                 load_en;
   logic [ADDR_BITS-1:0] load_addr;
   logic [7:0]           load_data;
   logic                 busy;

   modport slave (
      input  spi_select, spi_mosi, load_en, load_addr, load_data,
      output spi_miso, busy
   );

   modport master (
      output spi_select, spi_mosi, load_en, load_addr, load_data,
      input  spi_miso, busy
   );
endinterface

// File: rtl/spi_mem_responder.sv
// Byte-addressed SPI RAM model (READ 0x03 / WRITE 0x02) clocked by the CPU
// clock, one SPI bit per rising edge, with a side-band preload port.
module spi_mem_responder #(
   parameter int ADDR_BITS = 10
) (
   input logic               clk,
   input logic               rst,
   spi_mem_responder_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_READ,
      S_WRITE,
      S_IGNORE
   } state_t;

   state_t               state, state_n;
   logic [4:0]           cnt, cnt_n;
   logic [7:0]           cmd, cmd_n;
   logic [ADDR_BITS-1:0] addr, addr_n;
   logic [7:0]           data, data_n;
   logic                 miso_q, miso_n;
   logic                 wr_en;
   logic [7:0]           wr_data;
   logic [ADDR_BITS-1:0] addr_shift;
   logic [ADDR_BITS-1:0] addr_inc;
   logic [7:0]           data_shift;
   logic [7:0]           mem [DEPTH];

   assign addr_shift = {addr[ADDR_BITS-2:0], bus.spi_mosi};
   assign addr_inc   = addr + 1'b1;
   assign data_shift = {data[6:0], bus.spi_mosi};

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cmd_n   = cmd;
      addr_n  = addr;
      data_n  = data;
      miso_n  = 1'b0;
      wr_en   = 1'b0;
      wr_data = data_shift;
      case (state)
         S_IDLE: begin
            if (!bus.spi_select) begin
               state_n = S_CMD;
               cmd_n   = {7'd0, bus.spi_mosi};
               cnt_n   = 5'd1;
            end
         end
         S_CMD: begin
            cmd_n = {cmd[6:0], bus.spi_mosi};
            cnt_n = cnt + 5'd1;
            if (cnt == 5'd7) begin
               cnt_n   = 5'd0;
               state_n = (cmd_n == 8'h03 || cmd_n == 8'h02) ? S_ADDR : S_IGNORE;
            end
         end
         S_ADDR: begin
            addr_n = addr_shift;
            cnt_n  = cnt + 5'd1;
            if (cnt == 5'd23) begin
               cnt_n = 5'd0;
               // The first read bit must already be on miso when the CPU samples edge 32.
               if (cmd == 8'h03) begin
                  state_n = S_READ;
                  data_n  = mem[addr_shift];
                  miso_n  = mem[addr_shift][7];
               end else begin
                  state_n = S_WRITE;
                  data_n  = 8'd0;
               end
            end
         end
         S_READ: begin
            if (cnt == 5'd7) begin
               addr_n = addr_inc;
               data_n = mem[addr_inc];
               miso_n = mem[addr_inc][7];
               cnt_n  = 5'd0;
            end else begin
               data_n = {data[6:0], 1'b0};
               miso_n = data[6];
               cnt_n  = cnt + 5'd1;
            end
         end
         S_WRITE: begin
            data_n = data_shift;
            cnt_n  = cnt + 5'd1;
            if (cnt == 5'd7) begin
               wr_en  = 1'b1;
               addr_n = addr_inc;
               cnt_n  = 5'd0;
            end
         end
         default: begin
         end
      endcase
      if (bus.spi_select) begin
         state_n = S_IDLE;
         cnt_n   = 5'd0;
         miso_n  = 1'b0;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= 5'd0;
         cmd    <= 8'd0;
         addr   <= '0;
         data   <= 8'd0;
         miso_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         cmd    <= cmd_n;
         addr   <= addr_n;
         data   <= data_n;
         miso_q <= miso_n;
      end
   end

   // Memory survives reset; a same-edge load overrides an SPI write commit.
   always_ff @(posedge clk) begin
      if (bus.load_en) begin
         mem[bus.load_addr] <= bus.load_data;
      end else if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   assign bus.spi_miso = miso_q;
   assign bus.busy     = (state != S_IDLE);
endmodule
